// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types and mode encodings for the multi-channel PWM.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Per-channel waveform mode
    typedef logic [1:0] pwm_mode_t;

    localparam pwm_mode_t MODE_LEFT  = 2'd0;  // high while cnt <  cmp1
    localparam pwm_mode_t MODE_RIGHT = 2'd1;  // high while cnt >= cmp1
    localparam pwm_mode_t MODE_RANGE = 2'd2;  // high while cmp1 <= cnt < cmp2
    localparam pwm_mode_t MODE_RSVD  = 2'd3;  // reserved, held low

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_chan.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_chan
//  Description : One PWM channel: compares the shared counter against the
//                active compare values and registers the (inverted) level.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] cmp1,
    input  logic [W-1:0] cmp2,
    input  pwm_mode_t    mode,
    input  logic         inv,
    output logic         pwm_out
);

    logic w_raw;
    logic r_out;

    // Raw level from the current counter value and active compare set
    always_comb begin
        w_raw = 1'b0;
        case (mode)
            MODE_LEFT:  w_raw = (cnt < cmp1);
            MODE_RIGHT: w_raw = (cnt >= cmp1);
            MODE_RANGE: w_raw = (cnt >= cmp1) && (cnt < cmp2);
            default:    w_raw = 1'b0;
        endcase
    end

    // Output flop: gives the one-cycle latency and forces low while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 1'b0;
        end else begin
            r_out <= en & (w_raw ^ inv);
        end
    end

    assign pwm_out = r_out;

endmodule : pwm_chan
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi
//  Description : Multi-channel PWM with a shared prescaled timebase and
//                double-buffered per-channel configuration that switches
//                only at a counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 16,
    parameter int PW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pwm_en,
    input  logic [PW-1:0]   prescale,
    input  logic [W-1:0]    period,
    input  logic [CH*W-1:0] cmp1,
    input  logic [CH*W-1:0] cmp2,
    input  logic [CH*2-1:0] mode,
    input  logic [CH-1:0]   inv,
    input  logic            update_req,
    output logic            update_pending,
    output logic            update_done,
    output logic            period_irq,
    output logic [W-1:0]    count_val,
    output logic [CH-1:0]   pwm_out
);

    // Timebase
    logic [PW-1:0]   r_pre;
    logic [W-1:0]    r_cnt;

    // Staged configuration
    logic [W-1:0]    r_period_stg;
    logic [CH*W-1:0] r_cmp1_stg;
    logic [CH*W-1:0] r_cmp2_stg;
    logic [CH*2-1:0] r_mode_stg;
    logic [CH-1:0]   r_inv_stg;

    // Active configuration
    logic [W-1:0]    r_period_act;
    logic [CH*W-1:0] r_cmp1_act;
    logic [CH*W-1:0] r_cmp2_act;
    logic [CH*2-1:0] r_mode_act;
    logic [CH-1:0]   r_inv_act;

    logic            r_pending;
    logic            r_done;
    logic            r_irq;

    logic            w_tick;
    logic            w_wrap;
    logic            w_load_inputs;
    logic            w_load_staged;
    logic            w_stage;

    // Tick/wrap decode and config-load selection
    always_comb begin
        w_tick        = pwm_en && (r_pre == prescale);
        w_wrap        = w_tick && (r_cnt >= r_period_act);
        // Disabled: active tracks the inputs; a request landing on the wrap
        // bypasses staging entirely.
        w_load_inputs = !pwm_en || (w_wrap && update_req);
        w_load_staged = w_wrap && !update_req && r_pending;
        w_stage       = pwm_en && update_req && !w_wrap;
    end

    // Prescaler and period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (!pwm_en) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_cnt <= w_wrap ? '0 : r_cnt + W'(1);
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // Staged set: captured on every update request outside a wrap tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_stg <= '0;
            r_cmp1_stg   <= '0;
            r_cmp2_stg   <= '0;
            r_mode_stg   <= '0;
            r_inv_stg    <= '0;
        end else if (w_stage) begin
            r_period_stg <= period;
            r_cmp1_stg   <= cmp1;
            r_cmp2_stg   <= cmp2;
            r_mode_stg   <= mode;
            r_inv_stg    <= inv;
        end
    end

    // Active set: switches only at a wrap (or follows inputs while disabled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_act <= '0;
            r_cmp1_act   <= '0;
            r_cmp2_act   <= '0;
            r_mode_act   <= '0;
            r_inv_act    <= '0;
        end else if (w_load_inputs) begin
            r_period_act <= period;
            r_cmp1_act   <= cmp1;
            r_cmp2_act   <= cmp2;
            r_mode_act   <= mode;
            r_inv_act    <= inv;
        end else if (w_load_staged) begin
            r_period_act <= r_period_stg;
            r_cmp1_act   <= r_cmp1_stg;
            r_cmp2_act   <= r_cmp2_stg;
            r_mode_act   <= r_mode_stg;
            r_inv_act    <= r_inv_stg;
        end
    end

    // Pending flag and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_irq  <= w_wrap;
            r_done <= w_wrap && (update_req || r_pending);
            if (!pwm_en || w_wrap) begin
                r_pending <= 1'b0;
            end else if (update_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    generate
        for (genvar i = 0; i < CH; i++) begin : g_chan
            pwm_chan #(
                .W (W)
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (pwm_en),
                .cnt     (r_cnt),
                .cmp1    (r_cmp1_act[i*W +: W]),
                .cmp2    (r_cmp2_act[i*W +: W]),
                .mode    (pwm_mode_t'(r_mode_act[i*2 +: 2])),
                .inv     (r_inv_act[i]),
                .pwm_out (pwm_out[i])
            );
        end
    endgenerate

    assign update_pending = r_pending;
    assign update_done    = r_done;
    assign period_irq     = r_irq;
    assign count_val      = r_cnt;

endmodule : pwm_multi
`default_nettype wire
